// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter.
//   state_t : arbiter FSM states (IDLE, BUSY, RESP)
//   PORT_I  : grant / sel value for the instruction fetch port
//   PORT_D  : grant / sel value for the load/store port
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of every requester-side and memory-side signal of the arbiter.
//
// Handshake semantics (one rule for both requester ports):
//   A requester raises <x>_req together with its address (and for port D the
//   we/wdata fields) and holds all of them until it sees <x>_ack. <x>_ack is a
//   single-cycle pulse and <x>_rdata is valid in that cycle. The requester
//   drops <x>_req in the cycle after the ack; a req still high once the
//   arbiter is back in IDLE starts a new transaction. On the memory side
//   mem_req is high for the whole transaction and the memory answers with a
//   single mem_ack cycle carrying mem_rdata; mem_ack while mem_req is low is
//   ignored.
//
// Modports:
//   slave  : the arbiter (consumes requests, drives acks and the memory side)
//   master : the environment (requesters plus memory model)
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  logic              sel;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  logic              err;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    output i_ack, i_rdata, d_ack, d_rdata,
    output sel, mem_req, mem_we, mem_addr, mem_wdata, err
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata,
    input  sel, mem_req, mem_we, mem_addr, mem_wdata, err
  );

endinterface

// File: rtl/mem_port_arbiter_arb_rr2.sv
// Combinational two-way round-robin arbiter.
// Ports:
//   i_req       in  fetch port request
//   d_req       in  load/store port request
//   last        in  port granted most recently (PORT_I / PORT_D)
//   grant_valid out at least one request is present
//   grant       out winning port (PORT_I / PORT_D)
// A lone requester always wins; under contention the port that was not
// served last wins, so the two ports alternate and neither starves.
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
  input  logic last,
  output logic grant_valid,
  output logic grant
);

  always_comb begin
    grant_valid = i_req | d_req;
    grant       = PORT_I;
    if (i_req && d_req) begin
      grant = ~last;
    end else if (d_req) begin
      grant = PORT_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (port I) and load/store
// (port D). Each access is one memory transaction; the winner gets its read
// data with a one-cycle ack. Round-robin under contention.
//
// Parameters:
//   ADDR_W  : address width (requesters and memory)
//   DATA_W  : data width
//   TIMEOUT : watchdog limit in cycles (2..255), used with MEM_ARB_TIMEOUT_EN
//
// Ports:
//   clk       in  rising-edge clock
//   rst_n     in  asynchronous active-low reset
//   bus       slave modport of mem_port_arbiter_if (requester and memory side)
//   state_dbg out current FSM state
//
// Build option: define MEM_ARB_TIMEOUT_EN to add the BUSY watchdog. When it
// fires the winner is acked with rdata=0 and the sticky err flag is set.
// Without it BUSY waits for mem_ack indefinitely and err is tied low.
//
// Transaction timeline: request seen in IDLE at edge N -> BUSY (mem_req high)
// from N+1 -> mem_ack sampled at edge M -> RESP, ack high during cycle M+1 ->
// IDLE at M+2. sel/mem_addr/mem_we/mem_wdata are latched at the grant and do
// not move until the next grant.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mem_port_arbiter_if.slave     bus,
  output state_t                state_dbg
);

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_timeout_range
    $error("mem_port_arbiter: TIMEOUT must be within 2..255");
  end

  state_t            state_q, state_d;

  logic              grant_valid;
  logic              grant;

  // Control strobes from the FSM to the datapath registers.
  logic              load_grant;   // IDLE -> BUSY: latch winner and its request
  logic              capture;      // BUSY -> RESP on mem_ack
  logic              expire;       // BUSY -> RESP on watchdog
  logic              timeout_hit;

  logic              last_q;
  logic              sel_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              i_ack_q;
  logic              d_ack_q;

  arb_rr2 u_arb (
    .i_req       (bus.i_req),
    .d_req       (bus.d_req),
    .last        (last_q),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and datapath strobes
  always_comb begin
    state_d    = state_q;
    load_grant = 1'b0;
    capture    = 1'b0;
    expire     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d    = BUSY;
          load_grant = 1'b1;
        end
      end
      BUSY: begin
        // A real answer wins over a watchdog expiry in the same cycle.
        if (bus.mem_ack) begin
          state_d = RESP;
          capture = 1'b1;
        end else if (timeout_hit) begin
          state_d = RESP;
          expire  = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Grant latch, read data capture and ack pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q    <= PORT_D;
      sel_q     <= PORT_I;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
    end else begin
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      if (load_grant) begin
        sel_q  <= grant;
        last_q <= grant;
        if (grant == PORT_D) begin
          addr_q  <= bus.d_addr;
          we_q    <= bus.d_we;
          wdata_q <= bus.d_wdata;
        end else begin
          // Fetches never write; wdata keeps its old value and is unused.
          addr_q <= bus.i_addr;
          we_q   <= 1'b0;
        end
      end
      if (capture || expire) begin
        if (sel_q == PORT_D) begin
          d_rdata_q <= capture ? bus.mem_rdata : '0;
          d_ack_q   <= 1'b1;
        end else begin
          i_rdata_q <= capture ? bus.mem_rdata : '0;
          i_ack_q   <= 1'b1;
        end
      end
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  // Counts BUSY cycles without mem_ack; value k means k such cycles have
  // already ended, so hitting TIMEOUT-1 marks the TIMEOUT-th BUSY cycle.
  logic [7:0] wd_q;
  logic       err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (load_grant) begin
        wd_q <= '0;
      end else if (state_q == BUSY && !bus.mem_ack) begin
        wd_q <= wd_q + 8'd1;
      end
      if (expire) begin
        err_q <= 1'b1;
      end
    end
  end

  assign timeout_hit = (wd_q == 8'(TIMEOUT - 1));
  assign bus.err     = err_q;
`else
  assign timeout_hit = 1'b0;
  assign bus.err     = 1'b0;
`endif

  assign bus.sel       = sel_q;
  assign bus.mem_req   = (state_q == BUSY);
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.i_ack     = i_ack_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.d_rdata   = d_rdata_q;
  assign state_dbg     = state_q;

endmodule
